// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared widths, entry layout, FSM states and satp modes for the TLB
package tlb_pkg;

  localparam int VPN_W  = 36;
  localparam int PPN_W  = 44;
  localparam int ASID_W = 16;

  localparam logic [3:0] MODE_BARE = 4'd0;
  localparam logic [3:0] MODE_SV39 = 4'd8;
  localparam logic [3:0] MODE_SV48 = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    RESP = 2'd2
  } tlb_state_e;

  typedef struct packed {
    logic              valid;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_match.sv
// rtl/tlb_match.sv - parallel tag compare across all entries; lowest matching index wins
module tlb_match
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  tlb_entry_t [ENTRIES-1:0] entries,
  input  logic [VPN_W-1:0]         vpn,
  input  logic [ASID_W-1:0]        asid,
  output logic                     hit,
  output logic [IDX_W-1:0]         hit_idx
);

  logic [ENTRIES-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = entries[i].valid && (entries[i].vpn == vpn) && (entries[i].asid == asid);
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb.sv
// rtl/tlb.sv - fully-associative 4 KiB TLB with single outstanding walk
// TLB_ASID_EN: tag entries with satp.asid instead of flushing on any satp change.
module tlb
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_va,
  input  logic [63:0] satp,
  input  logic [1:0]  mmode,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] resp_pa,
  output logic        resp_fault,
  output logic        ptw_req,
  output logic [63:0] ptw_va,
  input  logic        ptw_valid,
  input  logic [63:0] ptw_pa,
  input  logic        ptw_done
);

  localparam int IDX_W = $clog2(ENTRIES);

  tlb_state_e state_q, state_d;
  logic [63:0] va_q, va_d, cap_pa_q, cap_pa_d, resp_pa_q, resp_pa_d;
  logic cap_q, cap_d, kill_q, kill_d;
  logic resp_valid_q, resp_valid_d, resp_fault_q, resp_fault_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  tlb_entry_t [ENTRIES-1:0] entries_q, entries_d;

  logic [3:0] mode;
  logic bypass, active, hit, inval, fill, have_pa;
  logic [IDX_W-1:0] hit_idx;
  logic [63:0] fill_pa;
  logic [ASID_W-1:0] tag_asid;

  assign mode   = satp[63:60];
  assign bypass = (mode == MODE_BARE) || (mmode == 2'b11);
  assign active = (mode == MODE_SV39) || (mode == MODE_SV48);

`ifdef TLB_ASID_EN
  logic unused_satp;
  assign unused_satp = ^satp[43:0];
  assign tag_asid    = satp[59:44];
  assign inval       = flush;
`else
  // Without ASID tagging, any satp change must drop every cached translation.
  logic [63:0] satp_q, satp_d;
  always_comb satp_d = satp;
  always_ff @(posedge clk) begin
    if (reset) satp_q <= '0;
    else       satp_q <= satp_d;
  end
  assign tag_asid = '0;
  assign inval    = flush || (satp != satp_q);
`endif

  tlb_match #(.ENTRIES(ENTRIES)) u_match (
    .entries (entries_q),
    .vpn     (req_va[47:12]),
    .asid    (tag_asid),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  // A strobe in the done cycle takes precedence over an earlier capture.
  assign have_pa = ptw_valid || cap_q;
  assign fill_pa = ptw_valid ? ptw_pa : cap_pa_q;

  always_comb begin
    state_d      = state_q;
    va_d         = va_q;
    cap_d        = cap_q;
    cap_pa_d     = cap_pa_q;
    kill_d       = kill_q;
    resp_valid_d = 1'b0;
    resp_pa_d    = resp_pa_q;
    resp_fault_d = resp_fault_q;
    fill         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (bypass) begin
            resp_pa_d    = req_va;
            resp_fault_d = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (!active) begin
            resp_pa_d    = '0;
            resp_fault_d = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else if (hit) begin
            resp_pa_d    = {8'b0, entries_q[hit_idx].ppn, req_va[11:0]};
            resp_fault_d = 1'b0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            va_d     = req_va;
            cap_d    = 1'b0;
            cap_pa_d = '0;
            kill_d   = 1'b0;
            state_d  = WALK;
          end
        end
      end
      WALK: begin
        if (ptw_valid) begin
          cap_d    = 1'b1;
          cap_pa_d = ptw_pa;
        end
        if (inval) kill_d = 1'b1;
        if (ptw_done) begin
          resp_valid_d = 1'b1;
          state_d      = RESP;
          if (have_pa) begin
            resp_pa_d    = fill_pa;
            resp_fault_d = 1'b0;
            fill         = !(kill_q || inval);
          end else begin
            resp_pa_d    = '0;
            resp_fault_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    entries_d = entries_q;
    ptr_d     = ptr_q;
    if (fill) begin
      entries_d[ptr_q] = '{valid: 1'b1, asid: tag_asid, vpn: va_q[47:12], ppn: fill_pa[55:12]};
      ptr_d            = ptr_q + 1'b1;
    end
    if (inval) begin
      for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      va_q         <= '0;
      cap_q        <= 1'b0;
      cap_pa_q     <= '0;
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_pa_q    <= '0;
      resp_fault_q <= 1'b0;
      ptr_q        <= '0;
      entries_q    <= '0;
    end else begin
      state_q      <= state_d;
      va_q         <= va_d;
      cap_q        <= cap_d;
      cap_pa_q     <= cap_pa_d;
      kill_q       <= kill_d;
      resp_valid_q <= resp_valid_d;
      resp_pa_q    <= resp_pa_d;
      resp_fault_q <= resp_fault_d;
      ptr_q        <= ptr_d;
      entries_q    <= entries_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_pa    = resp_pa_q;
  assign resp_fault = resp_fault_q;
  assign ptw_req    = (state_q == WALK);
  assign ptw_va     = va_q;

endmodule

// File: tb/tb_tlb.sv
// tb/tb_tlb.sv - directed bench for tlb with a simple walker model driven per request
module tb_tlb;

  localparam int ENTRIES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_va;
  logic [63:0] satp;
  logic [1:0]  mmode;
  logic        flush;
  logic        resp_valid;
  logic [63:0] resp_pa;
  logic        resp_fault;
  logic        ptw_req;
  logic [63:0] ptw_va;
  logic        ptw_valid;
  logic [63:0] ptw_pa;
  logic        ptw_done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [63:0] SATP_A = {4'h8, 16'h0001, 44'h0};
  localparam logic [63:0] SATP_B = {4'h8, 16'h0002, 44'h0};

  tlb #(.ENTRIES(ENTRIES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_va     (req_va),
    .satp       (satp),
    .mmode      (mmode),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_pa    (resp_pa),
    .resp_fault (resp_fault),
    .ptw_req    (ptw_req),
    .ptw_va     (ptw_va),
    .ptw_valid  (ptw_valid),
    .ptw_pa     (ptw_pa),
    .ptw_done   (ptw_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and play the walker if the TLB asks for a walk.
  task automatic xlate(input string tag, input logic [63:0] va, input bit give_pa,
                       input logic [63:0] pa, input int done_dly, input bit flush_mid,
                       input bit flush_at_req, input logic [63:0] exp_pa,
                       input bit exp_fault, input bit exp_walk);
    int cyc = 0;
    int wc = 0;
    bit got = 0;
    bit walked = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_va    = va;
    flush     = flush_at_req;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      ptw_valid = 1'b0;
      ptw_done  = 1'b0;
      flush     = 1'b0;
      if (resp_valid) begin
        got = 1;
      end else if (ptw_req) begin
        walked = 1;
        wc++;
        if (wc == 1) begin
          check({tag, ".ptw_va"}, ptw_va, va);
          ptw_valid = give_pa;
          ptw_pa    = pa;
        end
        if (flush_mid && wc == 2) flush = 1'b1;
        if (wc == 1 + done_dly) ptw_done = 1'b1;
      end
    end
    req_valid = 1'b0;
    check({tag, ".resp"}, 64'(got), 64'd1);
    check({tag, ".pa"}, resp_pa, exp_pa);
    check({tag, ".fault"}, 64'(resp_fault), 64'(exp_fault));
    check({tag, ".walk"}, 64'(walked), 64'(exp_walk));
    check({tag, ".lat"}, 64'(cyc), exp_walk ? 64'(done_dly + 2) : 64'd1);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(resp_valid), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_va    = '0;
    satp      = SATP_A;
    mmode     = 2'b00;
    flush     = 1'b0;
    ptw_valid = 1'b0;
    ptw_pa    = '0;
    ptw_done  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.resp_valid", 64'(resp_valid), 64'd0);
    check("rst.resp_pa", resp_pa, 64'd0);
    check("rst.resp_fault", 64'(resp_fault), 64'd0);
    check("rst.ptw_req", 64'(ptw_req), 64'd0);
    reset = 1'b0;

    mmode = 2'b11;
    xlate("bypass_m", 64'h8000_1234, 0, 0, 0, 0, 0, 64'h8000_1234, 0, 0);
    mmode = 2'b00;
    satp  = 64'd0;
    xlate("bypass_bare", 64'h1234_5678, 0, 0, 0, 0, 0, 64'h1234_5678, 0, 0);
    satp = {4'h5, 60'h0};
    xlate("bad_mode", 64'h4000_0000, 0, 0, 0, 0, 0, 64'h0, 1, 0);
    satp = SATP_A;

    xlate("miss", 64'h4000_0123, 1, 64'h8765_4123, 3, 0, 0, 64'h8765_4123, 0, 1);
    xlate("hit", 64'h4000_0ABC, 0, 0, 0, 0, 0, 64'h8765_4ABC, 0, 0);

    xlate("wfault", 64'h5000_0000, 0, 0, 2, 0, 0, 64'h0, 1, 1);
    xlate("wfault_again", 64'h5000_0000, 0, 0, 2, 0, 0, 64'h0, 1, 1);

    xlate("same_cyc", 64'h6000_0000, 1, 64'h1111_1000, 0, 0, 0, 64'h1111_1000, 0, 1);
    xlate("same_cyc_hit", 64'h6000_0004, 0, 0, 0, 0, 0, 64'h1111_1004, 0, 0);

    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int k = 0; k <= ENTRIES; k++) begin
      xlate($sformatf("ev%0d", k), 64'h7000_0000 + 64'(k) * 4096, 1,
            64'h2_0000_0000 + 64'(k) * 4096, 1, 0, 0,
            64'h2_0000_0000 + 64'(k) * 4096, 0, 1);
    end
    xlate("ev_second_hit", 64'h7000_1010, 0, 0, 0, 0, 0, 64'h2_0000_1010, 0, 0);
    xlate("ev_first_miss", 64'h7000_0020, 1, 64'h2_0000_0020, 1, 0, 0, 64'h2_0000_0020, 0, 1);

    xlate("flush_walk", 64'h9000_0000, 1, 64'h3333_3000, 3, 1, 0, 64'h3333_3000, 0, 1);
    xlate("flush_walk_remiss", 64'h9000_0000, 1, 64'h3333_3000, 3, 0, 0, 64'h3333_3000, 0, 1);
    xlate("flush_req_hit", 64'h9000_0008, 0, 0, 0, 0, 1, 64'h3333_3008, 0, 0);
    xlate("flush_req_after", 64'h9000_0008, 1, 64'h3333_3008, 1, 0, 0, 64'h3333_3008, 0, 1);

    xlate("asid_fill", 64'hA000_0000, 1, 64'h4444_4000, 1, 0, 0, 64'h4444_4000, 0, 1);
    satp = SATP_B;
    xlate("asid_other", 64'hA000_0000, 1, 64'h5555_5000, 1, 0, 0, 64'h5555_5000, 0, 1);
`ifdef TLB_ASID_EN
    satp = SATP_A;
    xlate("asid_orig_hit", 64'hA000_0010, 0, 0, 0, 0, 0, 64'h4444_4010, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
